// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder with a 32 x 8 register file in USB-host-shield command
// format: a status byte (HIRQ) goes out during the command byte, then
// auto-incrementing reads or writes follow. HIRQ is write-1-to-clear with
// local set pulses; IRQ flags any enabled pending interrupt.
module spi_reg_responder #(
    parameter int unsigned HIRQ_ADDR = 25,
    parameter int unsigned HIEN_ADDR = 26
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       SS_n,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_oe,
    input  logic [7:0] irq_set,
    input  logic [4:0] lcl_addr,
    output logic [7:0] lcl_rdata,
    output logic       wr_stb,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       IRQ
);

    localparam logic [4:0] HIRQ_A = 5'(HIRQ_ADDR);
    localparam logic [4:0] HIEN_A = 5'(HIEN_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] regs_q [32];

    logic       ss_meta_q, ss_sync_q, ss_prev_q;
    logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic       mosi_meta_q, mosi_sync_q;

    logic [2:0] bit_cnt_q;
    logic [7:0] rx_q;
    logic [7:0] tx_q;
    logic [4:0] addr_q;
    logic       wr_q;
    logic       load_pending_q;
    logic       oe_q;
    logic       wr_stb_q;
    logic [4:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       irq_q;

    logic       ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [7:0] rx_d;
    logic       spi_we;
    logic [7:0] hirq_d;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= SS_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sclk_meta_q <= SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Edge strobes, next rx byte, SPI write enable and next HIRQ value.
    always_comb begin
        ss_fall   = ss_prev_q & ~ss_sync_q;
        ss_rise   = ~ss_prev_q & ss_sync_q;
        sclk_rise = sclk_sync_q & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q & sclk_prev_q;
        rx_d      = {rx_q[6:0], mosi_sync_q};
        spi_we    = (state_q == DATA) && wr_q && sclk_rise &&
                    (bit_cnt_q == 3'd7) && !ss_rise;
        hirq_d    = regs_q[HIRQ_A];
        if (spi_we && (addr_q == HIRQ_A)) begin
            hirq_d = hirq_d & ~rx_d;
        end
        // Set is applied after the clear so a same-cycle set survives.
        hirq_d = hirq_d | irq_set;
    end

    // Transaction FSM: command decode, byte shifting and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_q           <= '0;
            tx_q           <= '0;
            addr_q         <= '0;
            wr_q           <= 1'b0;
            load_pending_q <= 1'b0;
            oe_q           <= 1'b0;
            wr_stb_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            irq_q    <= |(regs_q[HIRQ_A] & regs_q[HIEN_A]);
            if (ss_rise) begin
                state_q        <= IDLE;
                oe_q           <= 1'b0;
                tx_q           <= '0;
                bit_cnt_q      <= '0;
                load_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ss_fall) begin
                            state_q   <= CMD;
                            bit_cnt_q <= '0;
                            tx_q      <= regs_q[HIRQ_A];
                            oe_q      <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                addr_q         <= rx_d[7:3];
                                wr_q           <= rx_d[1];
                                load_pending_q <= ~rx_d[1];
                                state_q        <= DATA;
                            end
                        end else if (sclk_fall) begin
                            tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (wr_q) begin
                                    wr_stb_q  <= 1'b1;
                                    wr_addr_q <= addr_q;
                                    wr_data_q <= rx_d;
                                    addr_q    <= addr_q + 5'd1;
                                end else begin
                                    load_pending_q <= 1'b1;
                                end
                            end
                        end else if (sclk_fall) begin
                            if (load_pending_q && !wr_q) begin
                                tx_q           <= regs_q[addr_q];
                                addr_q         <= addr_q + 5'd1;
                                load_pending_q <= 1'b0;
                            end else begin
                                tx_q <= {tx_q[6:0], 1'b0};
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Register file: plain SPI writes, HIRQ is write-1-to-clear with local set.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            regs_q <= '{default: '0};
        end else begin
            if (spi_we && (addr_q != HIRQ_A)) begin
                regs_q[addr_q] <= rx_d;
            end
            regs_q[HIRQ_A] <= hirq_d;
        end
    end

    assign MISO      = tx_q[7];
    assign MISO_oe   = oe_q;
    assign lcl_rdata = regs_q[lcl_addr];
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign IRQ       = irq_q;

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 slave (responder) that answers the SOC's SPI master (SS_n/SCLK/MOSI/MISO) with a 32 x 8 register file using the USB-host-shield command format.
- Used as an on-FPGA stand-in for the shield during bring-up, and as a bench target for the SOC SPI path.
- Exposes a write strobe, a local read port and an interrupt line, so FPGA logic can act as the device side.

Parameters:
- HIRQ_ADDR, 25, register index of the interrupt-request register (write-1-to-clear).
- HIEN_ADDR, 26, register index of the interrupt-enable register.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_h  in  1  synchronous, active-high reset.
- SS_n  in  1  SPI chip select, active low; asynchronous to Clk.
- SCLK  in  1  SPI clock, idle low; asynchronous; frequency <= Clk/8.
- MOSI  in  1  SPI data from the master, MSB first.
- MISO  out  1  SPI data to the master, MSB first.
- MISO_oe  out  1  1 while selected; the top level tri-states MISO when this is 0.
- irq_set  in  8  per-bit set pulses into HIRQ (FPGA-side events).
- lcl_addr  in  5  local read address.
- lcl_rdata  out  8  combinational read of reg[lcl_addr].
- wr_stb  out  1  one-cycle pulse on each SPI register write.
- wr_addr  out  5  address of the write; valid with wr_stb.
- wr_data  out  8  data of the write; valid with wr_stb.
- IRQ  out  1  high when |(HIRQ & HIEN).

Behaviour:
Synchronisation and edge detection
- SS_n, SCLK and MOSI each pass through a 2-FF synchroniser.
- Edges are detected on the synchronised copies, so internal action lags the pin by 3 Clk cycles.
- MOSI is sampled on the detected SCLK rise. MISO shifts on the detected SCLK fall.

Reset values
- Reset clears all registers, the shift register, the bit counter, the address and the write flag.
- Reset state: state=IDLE, MISO=0, MISO_oe=0, wr_stb=0, wr_addr=0, wr_data=0, IRQ=0.
- Reset has priority over every other event.

State machine
- IDLE
  - Detected SS_n fall: go to CMD, bit counter=0, tx shift register loaded with HIRQ.
  - MISO = tx[7] from this point, MISO_oe=1.
- CMD
  - Shift 8 MOSI bits into rx.
  - On the 8th rise: addr=rx[7:3], wr=rx[1] (1=write, 0=read); rx[2] and rx[0] are ignored.
  - Go to DATA and set load_pending.
- DATA, read (wr=0)
  - On a fall with load_pending set: tx=reg[addr] (loaded instead of shifted), then addr=addr+1 and load_pending is cleared.
  - On each subsequent 8th rise: set load_pending again.
- DATA, write (wr=0 is read; wr=1 is write)
  - On each 8th rise: reg[addr] is written with rx, wr_stb pulses with that addr/data, addr=addr+1.
  - tx shifts out zeros.

Address and byte handling
- addr is 5 bits and wraps 31 -> 0.
- Falls that are not reloads shift tx left, filling with 0.

End of transaction
- Detected SS_n rise from any state: go to IDLE, MISO_oe=0, MISO=0.
- A partial byte (fewer than 8 bits) is discarded: no write, no wr_stb.
- SCLK edges while SS_n is high are ignored.

HIRQ register (write-1-to-clear)
- Bits written as 1 over SPI are cleared; bits written as 0 are unchanged.
- Same cycle, same bit, irq_set and SPI clear: set wins.
- irq_set ORs into HIRQ every cycle.
- All other registers are plain writes; HIEN is a plain register.

Other outputs and timing
- The status byte captures HIRQ at the moment of the SS_n fall.
- A read of HIRQ captures its value at the reload cycle.
- IRQ is registered: it updates 1 Clk after the HIRQ/HIEN change.
- lcl_rdata is combinational from the current contents of the register file.

Test Plan:
- Reset, then idle: MISO_oe=0, IRQ=0, lcl_rdata=0 for every lcl_addr 0..31.
- Write transaction, SS_n low, bytes 0x2A (addr 5, write), 0x11, 0x22 -> wr_stb pulses twice, (5,0x11) then (6,0x22); reg5=0x11, reg6=0x22.
- Read transaction 0x28 (addr 5, read) plus 2 dummy bytes -> MISO returns 0x11, 0x22.
- Read starting at addr 31 (cmd 0xF8) -> returns reg31 then reg0 (wrap-around).
- Interrupt path, in order:
  - irq_set=0x04 for 1 cycle with HIEN=0x00 -> IRQ stays 0, HIRQ=0x04.
  - Write HIEN (cmd 0xD2) with 0x04 -> IRQ=1.
  - Next transaction's status byte on MISO = 0x04.
  - Write HIRQ (cmd 0xCA) with 0x04 -> IRQ=0.
  - Same-cycle irq_set=0x04 during that write's commit -> HIRQ stays 0x04.
- Abort: command 0x2A, then 5 data bits, then SS_n high -> no wr_stb, reg5 unchanged. Next transaction starts cleanly with the status byte.
